// File: rtl/qos_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : qos_ctrl_fsm
// Brief    : Supervisory FSM for the QoS FIFO array: threshold distribution,
//            configuration sanity check, idle debounce, sticky error capture.
// Revision : 1.0
// ============================================================================
module qos_ctrl_fsm #(
    parameter int                   NUM_FIFOS = 5,
    parameter int                   THR_W     = 4,
    parameter int                   IDLE_CNT  = 4,
    parameter logic [NUM_FIFOS-1:0] ERR_MASK  = {NUM_FIFOS{1'b1}}
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         init,
    input  logic [NUM_FIFOS*THR_W-1:0]   cfg_high,
    input  logic [NUM_FIFOS*THR_W-1:0]   cfg_low,
    input  logic [NUM_FIFOS-1:0]         fifo_empty,
    input  logic [NUM_FIFOS-1:0]         fifo_error,
    input  logic                         err_clear,
    output logic [NUM_FIFOS*THR_W-1:0]   thr_high,
    output logic [NUM_FIFOS*THR_W-1:0]   thr_low,
    output logic [2:0]                   state_out,
    output logic                         init_out,
    output logic                         idle_out,
    output logic                         active_out,
    output logic                         error_out,
    output logic [NUM_FIFOS-1:0]         error_full,
    output logic                         cfg_error
);

    localparam logic [2:0] c_st_reset  = 3'd0;
    localparam logic [2:0] c_st_init   = 3'd1;
    localparam logic [2:0] c_st_idle   = 3'd2;
    localparam logic [2:0] c_st_active = 3'd3;
    localparam logic [2:0] c_st_error  = 3'd4;

    // Counter value seen on the last of IDLE_CNT consecutive all-empty cycles
    localparam logic [7:0] c_idle_last = 8'(IDLE_CNT - 1);

    logic [2:0]                 r_state;
    logic [2:0]                 w_next;
    logic [7:0]                 r_idle_cnt;
    logic [NUM_FIFOS*THR_W-1:0] r_thr_high;
    logic [NUM_FIFOS*THR_W-1:0] r_thr_low;
    logic [NUM_FIFOS-1:0]       r_error_full;
    logic                       r_cfg_error;
    logic                       r_init_flag;
    logic                       r_idle_flag;
    logic                       r_active_flag;
    logic                       r_error_flag;

    logic [NUM_FIFOS-1:0]       w_err_masked;
    logic                       w_err_hit;
    logic                       w_all_empty;
    logic [NUM_FIFOS-1:0]       w_slice_ok;
    logic                       w_cfg_ok;

    assign w_err_masked = fifo_error & ERR_MASK;
    assign w_err_hit    = |w_err_masked;
    assign w_all_empty  = &fifo_empty;
    assign w_cfg_ok     = &w_slice_ok;

    generate
        for (genvar gi = 0; gi < NUM_FIFOS; gi++) begin : g_cfg_chk
            assign w_slice_ok[gi] = (cfg_low[gi*THR_W +: THR_W] <= cfg_high[gi*THR_W +: THR_W]);
        end
    endgenerate

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_reset: begin
                if (init) w_next = c_st_init;
            end
            c_st_init: begin
                if (w_err_hit)        w_next = c_st_error;
                else if (init)        w_next = c_st_init;
                else if (!w_cfg_ok)   w_next = c_st_init;
                else if (w_all_empty) w_next = c_st_idle;
                else                  w_next = c_st_active;
            end
            c_st_idle: begin
                if (w_err_hit)         w_next = c_st_error;
                else if (init)         w_next = c_st_init;
                else if (!w_all_empty) w_next = c_st_active;
            end
            c_st_active: begin
                if (w_err_hit)                                  w_next = c_st_error;
                else if (init)                                  w_next = c_st_init;
                else if (w_all_empty && r_idle_cnt == c_idle_last) w_next = c_st_idle;
            end
            c_st_error: begin
                // init is deliberately ignored here; only a clean err_clear exits
                if (err_clear && !w_err_hit) w_next = c_st_init;
            end
            default: w_next = c_st_reset;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_st_reset;
            r_idle_cnt    <= 8'd0;
            r_thr_high    <= '0;
            r_thr_low     <= '0;
            r_error_full  <= '0;
            r_cfg_error   <= 1'b0;
            r_init_flag   <= 1'b0;
            r_idle_flag   <= 1'b0;
            r_active_flag <= 1'b0;
            r_error_flag  <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_init_flag   <= (w_next == c_st_init);
            r_idle_flag   <= (w_next == c_st_idle);
            r_active_flag <= (w_next == c_st_active);
            r_error_flag  <= (w_next == c_st_error);

            // Entry into ACTIVE and any busy cycle restart the debounce
            if (r_state == c_st_active && w_next == c_st_active && w_all_empty)
                r_idle_cnt <= r_idle_cnt + 8'd1;
            else
                r_idle_cnt <= 8'd0;

            if (r_state == c_st_init) begin
                r_cfg_error <= !w_cfg_ok;
                if (w_cfg_ok) begin
                    r_thr_high <= cfg_high;
                    r_thr_low  <= cfg_low;
                end
            end

            if (w_next == c_st_error)
                r_error_full <= r_error_full | w_err_masked;
            else if (r_state == c_st_error)
                r_error_full <= '0;
        end
    end

    assign thr_high   = r_thr_high;
    assign thr_low    = r_thr_low;
    assign state_out  = r_state;
    assign init_out   = r_init_flag;
    assign idle_out   = r_idle_flag;
    assign active_out = r_active_flag;
    assign error_out  = r_error_flag;
    assign error_full = r_error_full;
    assign cfg_error  = r_cfg_error;

endmodule
`default_nettype wire

// File: tb/tb_qos_ctrl_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_qos_ctrl_fsm
// Brief    : Scoreboard bench for qos_ctrl_fsm; two instances (full and
//            partial error mask) share stimulus, each with its own model.
// Revision : 1.0
// ============================================================================
module tb_qos_ctrl_fsm;

    localparam int             NF       = 5;
    localparam int             TW       = 4;
    localparam int             IDLE_CNT = 4;
    localparam logic [NF-1:0]  MASK0    = 5'b11111;
    localparam logic [NF-1:0]  MASK1    = 5'b11011;

    logic             clk = 1'b0;
    logic             reset, init, err_clear;
    logic [NF*TW-1:0] cfg_high, cfg_low;
    logic [NF-1:0]    fifo_empty, fifo_error;

    logic [NF*TW-1:0] thr_high0, thr_low0, thr_high1, thr_low1;
    logic [2:0]       state0, state1;
    logic             init0, idle0, act0, err0, init1, idle1, act1, err1;
    logic [NF-1:0]    ef0, ef1;
    logic             ce0, ce1;

    qos_ctrl_fsm #(.NUM_FIFOS(NF), .THR_W(TW), .IDLE_CNT(IDLE_CNT), .ERR_MASK(MASK0)) dut (
        .clk(clk), .reset(reset), .init(init), .cfg_high(cfg_high), .cfg_low(cfg_low),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error), .err_clear(err_clear),
        .thr_high(thr_high0), .thr_low(thr_low0), .state_out(state0),
        .init_out(init0), .idle_out(idle0), .active_out(act0), .error_out(err0),
        .error_full(ef0), .cfg_error(ce0));

    qos_ctrl_fsm #(.NUM_FIFOS(NF), .THR_W(TW), .IDLE_CNT(IDLE_CNT), .ERR_MASK(MASK1)) dut_m (
        .clk(clk), .reset(reset), .init(init), .cfg_high(cfg_high), .cfg_low(cfg_low),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error), .err_clear(err_clear),
        .thr_high(thr_high1), .thr_low(thr_low1), .state_out(state1),
        .init_out(init1), .idle_out(idle1), .active_out(act1), .error_out(err1),
        .error_full(ef1), .cfg_error(ce1));

    always #5 clk = ~clk;

    typedef struct {
        int               st;
        int               streak;
        logic [NF*TW-1:0] th;
        logic [NF*TW-1:0] tl;
        logic [NF-1:0]    ef;
        logic             ce;
    } model_t;

    typedef struct {
        model_t m0;
        model_t m1;
    } exp_t;

    exp_t   sb_q[$];
    exp_t   mon_e;
    model_t mdl0, mdl1;
    int     checks = 0;
    int     errors = 0;
    bit     active = 1'b0;

    // State after the next edge, derived from the behavioural rules:
    // 0 RESET, 1 INIT, 2 IDLE, 3 ACTIVE, 4 ERROR
    function automatic model_t next_model(model_t m, logic [NF-1:0] mask);
        model_t n;
        bit hit, ok, all_e;
        hit   = ((fifo_error & mask) != '0);
        all_e = (fifo_empty == '1);
        ok    = 1'b1;
        for (int i = 0; i < NF; i++)
            if (cfg_low[i*TW +: TW] > cfg_high[i*TW +: TW]) ok = 1'b0;
        n = m;
        if (reset) begin
            n.st = 0; n.streak = 0; n.th = '0; n.tl = '0; n.ef = '0; n.ce = 1'b0;
            return n;
        end
        case (m.st)
            0: if (init) n.st = 1;
            1: begin
                n.ce = !ok;
                if (ok) begin n.th = cfg_high; n.tl = cfg_low; end
                if (hit)             n.st = 4;
                else if (init || !ok) n.st = 1;
                else                 n.st = all_e ? 2 : 3;
            end
            2: n.st = hit ? 4 : init ? 1 : !all_e ? 3 : 2;
            3: begin
                if (hit)       n.st = 4;
                else if (init) n.st = 1;
                else if (all_e) begin
                    n.streak = m.streak + 1;
                    if (n.streak >= IDLE_CNT) n.st = 2;
                end else n.streak = 0;
            end
            4: begin
                if (err_clear && !hit) begin n.st = 1; n.ef = '0; end
                else n.ef = m.ef | (fifo_error & mask);
            end
            default: n.st = 0;
        endcase
        if (n.st == 4 && m.st != 4) n.ef = m.ef | (fifo_error & mask);
        if (n.st == 3 && m.st != 3) n.streak = 0;
        return n;
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
        end
    endtask

    task automatic cmp(input int inst, input model_t m, input logic [2:0] st, input logic [3:0] flags,
                       input logic [NF*TW-1:0] th, input logic [NF*TW-1:0] tl,
                       input logic [NF-1:0] ef, input logic ce);
        logic [3:0] ef_flags;
        ef_flags = {m.st == 1, m.st == 2, m.st == 3, m.st == 4};
        chk("state_out", inst, 32'(st), 32'(m.st));
        chk("flags", inst, 32'(flags), 32'(ef_flags));
        chk("thr_high", inst, 32'(th), 32'(m.th));
        chk("thr_low", inst, 32'(tl), 32'(m.tl));
        chk("error_full", inst, 32'(ef), 32'(m.ef));
        chk("cfg_error", inst, 32'(ce), 32'(m.ce));
    endtask

    // Monitor: every active edge must have a queued expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (active) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: got empty queue expected an entry at %0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    cmp(0, mon_e.m0, state0, {init0, idle0, act0, err0}, thr_high0, thr_low0, ef0, ce0);
                    cmp(1, mon_e.m1, state1, {init1, idle1, act1, err1}, thr_high1, thr_low1, ef1, ce1);
                end
            end
        end
    end

    task automatic tick();
        exp_t e;
        mdl0 = next_model(mdl0, MASK0);
        mdl1 = next_model(mdl1, MASK1);
        e.m0 = mdl0;
        e.m1 = mdl1;
        sb_q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int h;
        mdl0 = '{st: 0, streak: 0, th: '0, tl: '0, ef: '0, ce: 1'b0};
        mdl1 = mdl0;
        reset = 1'b1; init = 1'b0; err_clear = 1'b0;
        cfg_high = '0; cfg_low = '0; fifo_empty = '1; fifo_error = '0;
        active = 1'b1;

        ticks(3);
        reset = 1'b0; init = 1'b1;
        cfg_high = 20'hFFFFF; cfg_low = 20'h22222;
        ticks(2);

        // Bad slice on FIFO 3, then repaired
        init = 1'b0;
        cfg_low[3*TW +: TW] = 4'd9; cfg_high[3*TW +: TW] = 4'd4;
        tick();
        cfg_low[3*TW +: TW] = 4'd3;
        tick();

        // Idle debounce: 3 empty, 1 busy, then exactly 4 empty cycles
        fifo_empty = 5'b11110; tick();
        fifo_empty = '1;       ticks(3);
        fifo_empty = 5'b11110; tick();
        fifo_empty = '1;       ticks(4);

        // Error capture; the masked instance ignores FIFO 2
        fifo_empty = 5'b11110; tick();
        fifo_error = 5'b00100; tick();
        fifo_error = 5'b00001; tick();
        err_clear = 1'b1;      tick();
        fifo_error = '0;       tick();
        err_clear = 1'b0;      tick();

        // Reset with a simultaneous error, then init vs error in IDLE
        fifo_empty = '1; ticks(4);
        reset = 1'b1; fifo_error = 5'b11111; tick();
        reset = 1'b0; fifo_error = '0; init = 1'b1; tick();
        init = 1'b0; ticks(2);
        init = 1'b1; fifo_error = 5'b00010; tick();
        init = 1'b0; fifo_error = '0; err_clear = 1'b1; tick();
        err_clear = 1'b0; tick();

        for (int c = 0; c < 600; c++) begin
            reset      = ($urandom_range(63) == 0);
            init       = ($urandom_range(15) == 0);
            err_clear  = ($urandom_range(3) == 0);
            fifo_error = ($urandom_range(11) == 0) ? 5'($urandom) : '0;
            fifo_empty = ($urandom_range(3) != 0) ? '1 : 5'($urandom);
            if ($urandom_range(7) == 0) begin
                cfg_high = 20'($urandom);
                cfg_low  = 20'($urandom);
            end else if ($urandom_range(3) == 0) begin
                for (int i = 0; i < NF; i++) begin
                    h = int'($urandom_range(15));
                    cfg_high[i*TW +: TW] = 4'(h);
                    cfg_low[i*TW +: TW]  = 4'($urandom_range(h));
                end
            end
            tick();
        end

        active = 1'b0;
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
